// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Extra SRAM wait cycles per access when the instantiation does not override it.
  localparam int unsigned WAIT_CYCLES_DEF = 1;

  // Active-low byte-enable patterns; lane 0 is bits [7:0].
  localparam logic [3:0] BE_N_NONE = 4'b1111;
  localparam logic [3:0] BE_N_WORD = 4'b0000;
  localparam logic [3:0] BE_LANE0  = 4'b0001;

endpackage

// File: rtl/mem_access_if.sv
// Asynchronous SRAM bus between the memory-access stage and the SRAM.
//
// Bus protocol: the SRAM has no handshake. The master holds ram_ce_n low for the
// whole access window with ram_addr, ram_be_n and ram_wdata stable. A read keeps
// ram_oe_n low for the window and samples ram_rdata on its final clock edge. A
// write keeps ram_we_n low on every window cycle except the last one, which gives
// address/data hold time after ram_we_n rises. Outside a window every strobe is 1.
interface mem_access_if;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [3:0]  ram_be_n;

  modport master (
    output ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_wdata, ram_ce_n, ram_oe_n, ram_we_n, ram_be_n,
    output ram_rdata
  );
endinterface

// File: rtl/byte_lane.sv
// Byte-lane steering: load byte extract/sign-extend and store lane/byte-enable generation.
module byte_lane
  import mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic        is_byte,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  be_n
);

  logic [7:0] byte_sel;

  // Little-endian byte pick for loads; replicated byte and one-hot enable for stores.
  always_comb begin
    byte_sel = 8'(rdata >> {lane, 3'b000});
    if (is_byte) begin
      load_data = {{24{byte_sel[7]}}, byte_sel};
      wdata     = {4{store_data[7:0]}};
      be_n      = ~(BE_LANE0 << lane);
    end else begin
      load_data = rdata;
      wdata     = store_data;
      be_n      = BE_N_WORD;
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: sequences word/byte loads and stores to an
// asynchronous SRAM with a fixed wait count and produces the writeback strobe.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  result,
  input  logic [31:0]  mem_data,
  input  logic         if_mem_read,
  input  logic         if_mem_write,
  input  logic         load_byte,
  input  logic         if_reg_write_i,
  input  logic [4:0]   data_write_reg_i,
  output logic         mem_stall,
  output logic         wb_we,
  output logic [4:0]   wb_reg,
  output logic [31:0]  wb_data,
  output logic         align_err,
  output state_e       dbg_state,
  mem_access_if.master ram
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [21:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic        is_wr_q, is_wr_d;
  logic        is_byte_q, is_byte_d;
  logic [4:0]  dst_q, dst_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        align_err_q, align_err_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [3:0]  be_n_q, be_n_d;
  logic [31:0] wdata_q, wdata_d;

  logic        mem_req, misaligned, start;
  logic [31:0] load_data, lane_wdata;
  logic [3:0]  lane_be_n;

  // A request with both read and write high is handled as a read.
  assign mem_req    = if_mem_read | if_mem_write;
  assign misaligned = mem_req & ~load_byte & (result[1:0] != 2'b00);
  assign start      = (state_q == ST_IDLE) & mem_req & ~misaligned;
  assign mem_stall  = start | (state_q == ST_ACCESS);

  // Latch the access descriptor on the edge that leaves IDLE for ACCESS.
  always_comb begin
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    is_wr_d   = is_wr_q;
    is_byte_d = is_byte_q;
    dst_d     = dst_q;
    if (start) begin
      addr_d    = result[21:0];
      sdata_d   = mem_data;
      is_wr_d   = ~if_mem_read;
      is_byte_d = load_byte;
      dst_d     = data_write_reg_i;
    end
  end

  byte_lane u_byte_lane (
    .lane       (addr_d[1:0]),
    .is_byte    (is_byte_d),
    .store_data (sdata_d),
    .rdata      (ram.ram_rdata),
    .load_data  (load_data),
    .wdata      (lane_wdata),
    .be_n       (lane_be_n)
  );

  // Next-state, writeback and SRAM strobe computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wb_we_d     = 1'b0;
    wb_reg_d    = wb_reg_q;
    wb_data_d   = wb_data_q;
    align_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCESS;
          cnt_d   = 3'(WAIT_CYCLES);
        end else if (misaligned) begin
          align_err_d = 1'b1;
        end else if (!mem_req) begin
          wb_we_d   = if_reg_write_i & (data_write_reg_i != 5'd0);
          wb_reg_d  = data_write_reg_i;
          wb_data_d = result;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
          if (!is_wr_q) begin
            wb_we_d   = (dst_q != 5'd0);
            wb_reg_d  = dst_q;
            wb_data_d = load_data;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The final ACCESS cycle (counter at zero) releases ram_we_n for hold time.
    ce_n_d  = (state_d != ST_ACCESS);
    oe_n_d  = !((state_d == ST_ACCESS) && !is_wr_d);
    we_n_d  = !((state_d == ST_ACCESS) && is_wr_d && (cnt_d != 3'd0));
    be_n_d  = (state_d == ST_ACCESS) ? lane_be_n : BE_N_NONE;
    wdata_d = lane_wdata;
  end

  // All stage state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= 22'd0;
      sdata_q     <= 32'd0;
      is_wr_q     <= 1'b0;
      is_byte_q   <= 1'b0;
      dst_q       <= 5'd0;
      wb_we_q     <= 1'b0;
      wb_reg_q    <= 5'd0;
      wb_data_q   <= 32'd0;
      align_err_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= BE_N_NONE;
      wdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      is_wr_q     <= is_wr_d;
      is_byte_q   <= is_byte_d;
      dst_q       <= dst_d;
      wb_we_q     <= wb_we_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      align_err_q <= align_err_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      wdata_q     <= wdata_d;
    end
  end

  assign wb_we         = wb_we_q;
  assign wb_reg        = wb_reg_q;
  assign wb_data       = wb_data_q;
  assign align_err     = align_err_q;
  assign dbg_state     = state_q;
  assign ram.ram_addr  = addr_q[21:2];
  assign ram.ram_wdata = wdata_q;
  assign ram.ram_ce_n  = ce_n_q;
  assign ram.ram_oe_n  = oe_n_q;
  assign ram.ram_we_n  = we_n_q;
  assign ram.ram_be_n  = be_n_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random
// operations, each checked cycle by cycle against a timeline model.
module tb_mem_access;
  import mem_pkg::*;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] result, mem_data;
  logic        if_mem_read, if_mem_write, load_byte, if_reg_write_i;
  logic [4:0]  data_write_reg_i;
  logic        mem_stall, wb_we, align_err;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  state_e      dbg_state;

  int checks = 0;
  int failures = 0;
  int op_id = 0;
  int cyc = 0;

  // Clock
  always #5 clk = ~clk;

  mem_access_if bus ();

  mem_access #(.WAIT_CYCLES(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .result           (result),
    .mem_data         (mem_data),
    .if_mem_read      (if_mem_read),
    .if_mem_write     (if_mem_write),
    .load_byte        (load_byte),
    .if_reg_write_i   (if_reg_write_i),
    .data_write_reg_i (data_write_reg_i),
    .mem_stall        (mem_stall),
    .wb_we            (wb_we),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .align_err        (align_err),
    .dbg_state        (dbg_state),
    .ram              (bus.master)
  );

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s op=%0d cyc=%0d obs=%0b exp=%0b", tag, op_id, cyc, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s op=%0d cyc=%0d obs=%h exp=%h", tag, op_id, cyc, obs, exp);
    end
  endtask

  task automatic drive_nop();
    if_mem_read      = 1'b0;
    if_mem_write     = 1'b0;
    load_byte        = 1'b0;
    if_reg_write_i   = 1'b0;
    data_write_reg_i = 5'd0;
    result           = 32'd0;
    mem_data         = 32'd0;
  endtask

  // Presents one instruction at a negedge and checks W+4 cycles of outputs.
  // Cycle 0 is the cycle the instruction is presented in.
  task automatic run_op(input bit rd, input bit wr, input bit byt, input bit regw,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input logic [4:0] dst);
    bit          mem, mis, go, acc, exp_we;
    int          a, hold;
    logic [31:0] b, ld_exp, st_exp;
    logic [3:0]  be_exp;
    op_id++;
    mem    = rd | wr;
    mis    = mem && !byt && (addr[1:0] != 2'b00);
    go     = mem && !mis;
    hold   = go ? W + 1 : 0;
    a      = int'(addr[1:0]);
    b      = (rdata >> (8 * a)) & 32'hFF;
    ld_exp = !byt ? rdata : (b >= 32'd128 ? b - 32'd256 : b);
    st_exp = byt ? (data & 32'hFF) * 32'h01010101 : data;
    be_exp = byt ? (4'hF ^ (4'b0001 << a)) : 4'h0;
    if_mem_read      = rd;
    if_mem_write     = wr;
    load_byte        = byt;
    if_reg_write_i   = regw;
    data_write_reg_i = dst;
    result           = addr;
    mem_data         = data;
    bus.ram_rdata    = rdata;
    for (int c = 0; c <= W + 3; c++) begin
      #1;
      cyc    = c;
      acc    = go && (c >= 1) && (c <= W + 1);
      exp_we = (!mem && c == 1 && regw && dst != 5'd0) ||
               (go && rd && c == W + 2 && dst != 5'd0);
      check_b("mem_stall", mem_stall, go && (c <= W + 1));
      check_b("ram_ce_n", bus.ram_ce_n, !acc);
      check_b("ram_oe_n", bus.ram_oe_n, !(acc && rd));
      check_b("ram_we_n", bus.ram_we_n, !(acc && !rd && c <= W));
      check_b("align_err", align_err, mis && c == 1);
      check_b("wb_we", wb_we, exp_we);
      check_w("state", {30'd0, dbg_state},
              {30'd0, acc ? ST_ACCESS : ((go && c == W + 2) ? ST_DONE : ST_IDLE)});
      if (acc) begin
        check_w("ram_addr", {12'd0, bus.ram_addr}, (addr >> 2) & 32'hFFFFF);
        if (!(rd && byt)) check_w("ram_be_n", {28'd0, bus.ram_be_n}, {28'd0, be_exp});
        if (!rd) check_w("ram_wdata", bus.ram_wdata, st_exp);
      end else begin
        check_w("ram_be_n_idle", {28'd0, bus.ram_be_n}, 32'hF);
      end
      if (!mem && c == 1) begin
        check_w("wb_data_alu", wb_data, addr);
        check_w("wb_reg_alu", {27'd0, wb_reg}, {27'd0, dst});
      end
      if (go && rd && c == W + 2 && dst != 5'd0) begin
        check_w("wb_data_load", wb_data, ld_exp);
        check_w("wb_reg_load", {27'd0, wb_reg}, {27'd0, dst});
      end
      @(posedge clk);
      @(negedge clk);
      if (c == hold) drive_nop();
    end
  endtask

  initial begin
    int kind;
    bit rd, wr, byt;
    logic [31:0] addr;
    drive_nop();
    bus.ram_rdata = 32'd0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check_b("rst_wb_we", wb_we, 1'b0);
    check_w("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
    check_w("rst_wb_data", wb_data, 32'd0);
    check_b("rst_align_err", align_err, 1'b0);
    check_b("rst_ce_n", bus.ram_ce_n, 1'b1);
    check_b("rst_oe_n", bus.ram_oe_n, 1'b1);
    check_b("rst_we_n", bus.ram_we_n, 1'b1);
    check_w("rst_be_n", {28'd0, bus.ram_be_n}, 32'hF);
    check_w("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: LW, two LBs, SB, misaligned SW, ALU ops to r0 and r3
    run_op(1, 0, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5);
    run_op(1, 0, 1, 1, 32'h103, 32'h0, 32'h80112233, 5'd7);
    run_op(1, 0, 1, 1, 32'h101, 32'h0, 32'h80112233, 5'd8);
    run_op(0, 1, 1, 0, 32'h102, 32'h000000A5, 32'h0, 5'd0);
    run_op(0, 1, 0, 0, 32'h106, 32'h12345678, 32'h0, 5'd0);
    run_op(0, 0, 0, 1, 32'h7, 32'h0, 32'h0, 5'd0);
    run_op(0, 0, 0, 1, 32'h7, 32'h0, 32'h0, 5'd3);

    // Directed: reset in the middle of an LW aborts it with no writeback
    op_id++;
    if_mem_read = 1'b1; result = 32'h200; data_write_reg_i = 5'd9; if_reg_write_i = 1'b1;
    bus.ram_rdata = 32'h13572468;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_b("mid_oe_n_before", bus.ram_oe_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check_b("mid_ce_n", bus.ram_ce_n, 1'b1);
    check_b("mid_oe_n", bus.ram_oe_n, 1'b1);
    check_b("mid_we_n", bus.ram_we_n, 1'b1);
    check_w("mid_be_n", {28'd0, bus.ram_be_n}, 32'hF);
    check_w("mid_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      cyc = c;
      check_b("post_rst_wb_we", wb_we, 1'b0);
      check_b("post_rst_ce_n", bus.ram_ce_n, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    run_op(1, 0, 0, 1, 32'h204, 32'h0, 32'hCAFEF00D, 5'd9);

    // Random operations
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 5);
      rd   = (kind == 1) || (kind == 2) || (kind == 5);
      wr   = (kind == 3) || (kind == 4) || (kind == 5);
      byt  = (kind == 2) || (kind == 4) || ((kind == 5) && ($urandom_range(0, 1) == 1));
      addr = $urandom;
      if ((kind == 1 || kind == 3 || kind == 5) && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      run_op(rd, wr, byt, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
             5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: WAIT_CYCLES, 1, extra SRAM wait cycles per access, legal range 0..7.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 result  input  32  ALU result from the execute stage; byte address for memory ops.
REQ-005 mem_data  input  32  store data from the execute stage.
REQ-006 if_mem_read / if_mem_write  input  1 each  memory read / write request; both high is illegal and is treated as read.
REQ-007 load_byte  input  1  byte access (LB/SB) when high, word access (LW/SW) when low.
REQ-008 if_reg_write_i  input  1  instruction writes a register.
REQ-009 data_write_reg_i  input  5  destination register.
REQ-010 mem_stall  output  1  high while an access is in flight; upstream holds all inputs.
REQ-011 wb_we  output  1  one-cycle writeback strobe.
REQ-012 wb_reg  output  5  writeback register.
REQ-013 wb_data  output  32  writeback data.
REQ-014 align_err  output  1  one-cycle pulse on a misaligned word access.
REQ-015 ram_addr  output  20  SRAM word address, equal to result[21:2].
REQ-016 ram_wdata  output  32  SRAM write data.
REQ-017 ram_rdata  input  32  SRAM read data.
REQ-018 ram_ce_n, ram_oe_n, ram_we_n  output  1 each  active-low SRAM strobes.
REQ-019 ram_be_n  output  4  active-low byte enables; lane 0 = bits [7:0].

Function
REQ-020 States SHALL be IDLE, ACCESS and DONE.
REQ-021 Inputs SHALL be sampled only on a rising edge where state=IDLE.
REQ-022 Non-memory op in IDLE: next cycle wb_we=if_reg_write_i, wb_data=result, wb_reg=data_write_reg_i; no SRAM strobes; mem_stall stays 0.
REQ-023 Aligned memory op in IDLE: latch address, data, op and register, then enter ACCESS.
REQ-024 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, tracked by a 3-bit down-counter.
REQ-025 In ACCESS: ram_ce_n=0; reads drive ram_oe_n=0; writes drive ram_we_n=0 on every ACCESS cycle except the last, which deasserts ram_we_n for hold time.
REQ-026 Read data SHALL be captured from ram_rdata on the final ACCESS edge, then the block enters DONE.
REQ-027 DONE lasts one cycle: loads pulse wb_we with the formatted data; stores keep wb_we=0; next state is IDLE.
REQ-028 mem_stall SHALL be combinational: high whenever state is ACCESS, and in IDLE when a memory op is presented; low in DONE.
REQ-029 Load/store latency: request edge to wb_we = WAIT_CYCLES+2 cycles.
REQ-030 Word access: ram_be_n=4'b0000; ram_wdata=mem_data.
REQ-031 Byte store: exactly one ram_be_n bit is low, selected by result[1:0]; ram_wdata carries mem_data[7:0] replicated into all 4 lanes.
REQ-032 Byte load: byte selected by result[1:0] (little-endian), sign-extended to 32 bits.
REQ-033 Word op with result[1:0]!=0: no SRAM access, no writeback, align_err pulses for one cycle the next cycle, state stays IDLE.
REQ-034 wb_we SHALL be forced 0 when wb_reg=0.
REQ-035 Outside ACCESS, all ram_*_n strobes are 1 and ram_be_n=4'b1111.

Reset
REQ-036 Asserting rst_n low SHALL immediately force: state=IDLE, counter=0, wb_we=0, wb_reg=0, wb_data=0, align_err=0, ram_ce_n=ram_oe_n=ram_we_n=1, ram_be_n=4'b1111.
REQ-037 Reset during ACCESS SHALL abort the access with no writeback; the first request after release is handled normally.

Structure
REQ-038 Package mem_pkg SHALL hold the state enum, WAIT_CYCLES default, and the byte-lane constants.
REQ-039 Sub-module byte_lane SHALL hold the combinational load extract/sign-extend and store lane/byte-enable generation; mem_access instantiates it once.

Verification
REQ-040 WAIT_CYCLES=1, LW addr 0x100, ram_rdata=0xDEADBEEF, reg 5 -> ram_addr=0x40 with oe_n low for 2 cycles; wb_we with wb_data=0xDEADBEEF, wb_reg=5 on cycle 3; mem_stall high cycles 0-2.
REQ-041 LB addr 0x103, ram_rdata=0x80112233 -> wb_data=0xFFFFFF80; at addr 0x101 -> wb_data=0x00000022.
REQ-042 SB addr 0x102, mem_data=0x000000A5 -> ram_be_n=4'b1011, ram_wdata=0xA5A5A5A5, we_n low for WAIT_CYCLES cycles, no wb_we.
REQ-043 SW addr 0x106 -> align_err single pulse, strobes never asserted, mem_stall remains 0.
REQ-044 ADDU result=0x7, reg 0 -> wb_we=0; same result with reg 3 -> wb_we=1 and wb_data=0x7 the next cycle.
REQ-045 rst_n low mid-ACCESS of an LW -> all strobes high immediately, no wb_we; a following LW completes correctly.
